fetch_decode: RTL
=================

Name: fetch_decode

Overview:
- Front-end stage directly upstream of the register-file/ALU datapath.
- Owns the PC and fetches one 32-bit RV32I instruction at a time from instruction memory over a valid/ready request and valid response interface.
- Decodes the instruction into the fields the datapath consumes: rs1, rs2, rd, opcode[6:2], func3, func7, sign-extended imm, reg_write.
- Holds the decoded bundle under a valid/ready handshake until the datapath accepts it.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_addr  out  32  fetch address; equals pc.
imem_rsp_valid  in  1  instruction data valid.
imem_rsp_data  in  32  instruction word.
dec_valid  out  1  decoded bundle valid.
dec_ready  in  1  datapath accepts bundle.
pc  out  32  address of the current/decoded instruction.
opcode  out  5  instr[6:2].
func3  out  3  instr[14:12].
func7  out  7  instr[31:25].
rs1  out  5  instr[19:15].
rs2  out  5  instr[24:20].
rd  out  5  instr[11:7].
imm  out  32  sign-extended immediate.
reg_write  out  1  instruction writes rd.
illegal  out  1  bundle is an unsupported encoding.

Behaviour:
- Clock and reset: one clock. Reset is sampled only on the rising clock edge while low; it is synchronous and active-low.
- Reset values:
  - State REQ.
  - pc = RESET_PC.
  - dec_valid, illegal and reg_write = 0.
  - opcode, func3, func7, rs1, rs2, rd and imm = 0.
  - imem_req_valid = 0 while reset is low.
- Registered state machine REQ -> WAIT -> HOLD -> REQ.
- REQ:
  - imem_req_valid = 1, imem_addr = pc.
  - On imem_req_valid && imem_req_ready, go to WAIT.
  - imem_rsp_valid is ignored in REQ.
- WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid, register the decoded fields, set dec_valid = 1 and go to HOLD.
  - Response may arrive at earliest the cycle after request acceptance; unbounded wait allowed.
- HOLD:
  - dec_valid = 1; all outputs stable while dec_ready = 0.
  - On dec_ready: dec_valid drops next cycle, pc <= pc + 4 (mod 2^32, 0xFFFF_FFFC wraps to 0x0000_0000), go to REQ.
  - imem_rsp_valid is ignored in HOLD.
- Latency and throughput: dec_valid rises the cycle after imem_rsp_valid. Throughput is at best one instruction per 3 cycles (no pipelining, one outstanding request).
- Decode by instr[6:0]; imm sign bit is always instr[31]:
  - R (0110011): imm = 0, reg_write = 1.
  - I: OP-IMM 0010011, LOAD 0000011, JALR 1100111. imm = sext(instr[31:20]), reg_write = 1.
  - S (0100011): imm = sext({instr[31:25], instr[11:7]}), reg_write = 0.
  - B (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), reg_write = 0.
  - U: LUI 0110111, AUIPC 0010111. imm = {instr[31:12], 12'b0}, reg_write = 1.
  - J (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}), reg_write = 1.
  - reg_write is forced to 0 when rd == 0.
  - Any other opcode, or instr[1:0] != 2'b11: illegal = 1, reg_write = 0, imm = 0. Raw fields are still presented. The bundle is delivered normally and pc still advances on acceptance.
- Reset mid-operation:
  - Reset in any state returns to the reset values above.
  - An outstanding response arriving after reset, while in REQ, is discarded.
  - First request after reset release is at RESET_PC.

Test Plan:
1. Reset, then memory returns 0x00500093 (addi x1,x0,5) one cycle after accept -> dec_valid next cycle; pc=0, opcode=5'b00100, rd=1, rs1=0, func3=0, imm=0x00000005, reg_write=1, illegal=0.
2. Fetch 0xFFF00113 (addi x2,x0,-1) -> imm=0xFFFFFFFF, rd=2, reg_write=1. Fetch 0x00112423 (sw x1,8(x2)) -> imm=0x00000008, rs1=2, rs2=1, func3=3'b010, reg_write=0.
3. Fetch 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, reg_write=0. Fetch 0x000000EF (jal x1,0) -> imm=0, reg_write=1.
4. Hold dec_ready=0 for 5 cycles in HOLD -> all outputs and pc unchanged, imem_req_valid=0. Raise dec_ready -> next cycle dec_valid=0, imem_req_valid=1, imem_addr=0x00000004. Hold imem_req_ready low 3 cycles -> stays in REQ with the address stable.
5. Fetch 0x00000000 -> illegal=1, reg_write=0, imm=0. On accept, pc advances by 4. Fetch 0x00000013 with rd=0 (nop) -> reg_write=0, illegal=0.
6. Drive reset low during WAIT, then release and send a late imem_rsp_valid -> response ignored, dec_valid stays 0, new request at RESET_PC. With RESET_PC=0xFFFFFFFC, after one accepted bundle imem_addr=0x00000000.

Source files
------------

// File: rtl/fetch_decode.sv
// Single-issue RV32I fetch/decode front end: one outstanding fetch, decoded
// bundle held under valid/ready until the datapath takes it.
module fetch_decode #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] pc,
   output logic [4:0]  opcode,
   output logic [2:0]  func3,
   output logic [6:0]  func7,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [31:0] imm,
   output logic        reg_write,
   output logic        illegal
);

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_next;
   logic        load_bundle;

   logic [31:0] instr;
   logic [31:0] imm_d;
   logic        reg_write_d;
   logic        illegal_d;

   assign instr = imem_rsp_data;

   // Immediate and write-enable come from the major opcode; anything not
   // recognised is flagged illegal but still carries its raw fields.
   always_comb begin
      imm_d       = 32'h0;
      reg_write_d = 1'b0;
      illegal_d   = 1'b1;
      if (instr[1:0] == 2'b11) begin
         case (instr[6:2])
            5'b01100: begin
               illegal_d   = 1'b0;
               reg_write_d = 1'b1;
            end
            5'b00100, 5'b00000, 5'b11001: begin
               illegal_d   = 1'b0;
               reg_write_d = 1'b1;
               imm_d       = {{20{instr[31]}}, instr[31:20]};
            end
            5'b01000: begin
               illegal_d = 1'b0;
               imm_d     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            5'b11000: begin
               illegal_d = 1'b0;
               imm_d     = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            end
            5'b01101, 5'b00101: begin
               illegal_d   = 1'b0;
               reg_write_d = 1'b1;
               imm_d       = {instr[31:12], 12'h000};
            end
            5'b11011: begin
               illegal_d   = 1'b0;
               reg_write_d = 1'b1;
               imm_d       = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            end
            default: begin
               illegal_d = 1'b1;
            end
         endcase
      end
      if (instr[11:7] == 5'd0) begin
         reg_write_d = 1'b0;
      end
   end

   // Next-state and handshake outputs; the request is suppressed while reset
   // is held so memory never sees a fetch from a stale pc.
   always_comb begin
      state_next     = state;
      pc_next        = pc;
      load_bundle    = 1'b0;
      imem_req_valid = 1'b0;
      dec_valid      = 1'b0;
      case (state)
         REQ: begin
            imem_req_valid = reset;
            if (imem_req_valid && imem_req_ready) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               load_bundle = 1'b1;
               state_next  = HOLD;
            end
         end
         HOLD: begin
            dec_valid = 1'b1;
            if (dec_ready) begin
               pc_next    = pc + 32'd4;
               state_next = REQ;
            end
         end
         default: begin
            state_next = REQ;
         end
      endcase
   end

   assign imem_addr = pc;

   // State, pc and the decoded bundle registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= REQ;
         pc        <= RESET_PC;
         opcode    <= 5'd0;
         func3     <= 3'd0;
         func7     <= 7'd0;
         rs1       <= 5'd0;
         rs2       <= 5'd0;
         rd        <= 5'd0;
         imm       <= 32'h0;
         reg_write <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (load_bundle) begin
            opcode    <= instr[6:2];
            func3     <= instr[14:12];
            func7     <= instr[31:25];
            rs1       <= instr[19:15];
            rs2       <= instr[24:20];
            rd        <= instr[11:7];
            imm       <= imm_d;
            reg_write <= reg_write_d & ~illegal_d;
            illegal   <= illegal_d;
         end
      end
   end

endmodule
